uart_tx_ctl: RTL and testbench

//   Sequences UART transmit frames, paced by the 16x oversample enable from uart_baud_gen.

---
 rtl/uart_tx_ctl.sv | 158 +++++++++++++++
 tb/tb_uart_tx_ctl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctl.sv
// uart_tx_ctl: UART transmit frame sequencer.
// Pops characters from a first-word-fall-through FIFO and shifts them out as
// start bit, DATA_WIDTH data bits (LSB first), optional parity, then STOP_BITS
// stop bits. All timing comes from the 16x oversample enable (baud_x16_en).
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_ctl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_x16_en,
    input  logic                  char_fifo_empty,
    input  logic [DATA_WIDTH-1:0] char_fifo_dout,
    output logic                  char_fifo_rd_en,
    output logic                  txd_tx,
    output logic                  tx_busy
);

    localparam int BCW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            os_cnt, os_cnt_nxt;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
    logic                  stop_cnt, stop_cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  txd_nxt;
    logic                  rd_en_nxt;
    logic                  busy_nxt;
    logic                  launch;

    // Next-state and next-output logic; everything holds unless a baud pulse arrives.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_nxt    = state;
        os_cnt_nxt   = os_cnt;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        shreg_nxt    = shreg;
        txd_nxt      = txd_tx;
        rd_en_nxt    = 1'b0;
        busy_nxt     = tx_busy;
        launch       = 1'b0;

        if (baud_x16_en) begin
            if (state == IDLE) begin
                txd_nxt = 1'b1;
                launch  = !char_fifo_empty;
            end else if (os_cnt != 4'd0) begin
                os_cnt_nxt = os_cnt - 4'd1;
            end else begin
                // Current bit has been held for 16 pulses: move to the next bit.
                os_cnt_nxt = 4'd15;
                case (state)
                    START: begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                        txd_nxt     = shreg[0];
                    end
                    DATA: begin
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_nxt = PARITY;
                            txd_nxt   = (^shreg) ^ 1'(PARITY_ODD);
`else
                            state_nxt    = STOP;
                            stop_cnt_nxt = 1'b0;
                            txd_nxt      = 1'b1;
`endif
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                            txd_nxt     = shreg[bit_cnt + 1'b1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state_nxt    = STOP;
                        stop_cnt_nxt = 1'b0;
                        txd_nxt      = 1'b1;
                    end
`endif
                    STOP: begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            if (!char_fifo_empty) begin
                                // Back-to-back frame: no idle gap.
                                launch = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                                busy_nxt  = 1'b0;
                                txd_nxt   = 1'b1;
                            end
                        end else begin
                            stop_cnt_nxt = stop_cnt + 1'b1;
                            txd_nxt      = 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        txd_nxt   = 1'b1;
                    end
                endcase
            end

            // Launch overrides whatever the bit sequencing above decided.
            if (launch) begin
                shreg_nxt    = char_fifo_dout;
                rd_en_nxt    = 1'b1;
                txd_nxt      = 1'b0;
                os_cnt_nxt   = 4'd15;
                bit_cnt_nxt  = '0;
                stop_cnt_nxt = 1'b0;
                state_nxt    = START;
                busy_nxt     = 1'b1;
            end
        end
    end

    // State, counter, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            os_cnt          <= 4'd0;
            bit_cnt         <= '0;
            stop_cnt        <= 1'b0;
            // NOTE: the shift register is cleared too; it is a plain register, not
            // a memory array, so resetting it is cheap and keeps reset state clean.
            shreg           <= '0;
            txd_tx          <= 1'b1;
            char_fifo_rd_en <= 1'b0;
            tx_busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state           <= state_nxt;
            os_cnt          <= os_cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            stop_cnt        <= stop_cnt_nxt;
            shreg           <= shreg_nxt;
            txd_tx          <= txd_nxt;
            char_fifo_rd_en <= rd_en_nxt;
            tx_busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// tb_uart_tx_ctl: self-checking bench for uart_tx_ctl.
// Two instances share clock, reset and baud enable: dut0 uses the defaults,
// dut1 uses STOP_BITS=2 and PARITY_ODD=1. Each sees an identical character
// stream from its own FIFO model. A pulse-counting frame model predicts txd,
// tx_busy and rd_en every clock; literal checks pin the model per scenario.
module tb_uart_tx_ctl;

`ifdef UART_TX_PARITY_EN
    localparam int PBITS  = 1;
    localparam int FRAME0 = 176;
    localparam int FRAME1 = 192;
`else
    localparam int PBITS  = 0;
    localparam int FRAME0 = 160;
    localparam int FRAME1 = 176;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_x16_en = 1'b0;
    logic [1:0] fifo_empty;
    logic [7:0] fifo_dout [2];
    logic [1:0] rd_en;
    logic [1:0] txd;
    logic [1:0] busy;

    // Character stream shared by both FIFOs; each FIFO has its own read pointer.
    logic [7:0] push_mem [64];
    int         push_cnt = 0;
    int         erd [2] = '{0, 0};

    assign fifo_empty[0] = (erd[0] == push_cnt);
    assign fifo_empty[1] = (erd[1] == push_cnt);
    assign fifo_dout[0]  = push_mem[erd[0] % 64];
    assign fifo_dout[1]  = push_mem[erd[1] % 64];

    uart_tx_ctl #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .baud_x16_en     (baud_x16_en),
        .char_fifo_empty (fifo_empty[0]),
        .char_fifo_dout  (fifo_dout[0]),
        .char_fifo_rd_en (rd_en[0]),
        .txd_tx          (txd[0]),
        .tx_busy         (busy[0])
    );

    uart_tx_ctl #(.DATA_WIDTH(8), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .baud_x16_en     (baud_x16_en),
        .char_fifo_empty (fifo_empty[1]),
        .char_fifo_dout  (fifo_dout[1]),
        .char_fifo_rd_en (rd_en[1]),
        .txd_tx          (txd[1]),
        .tx_busy         (busy[1])
    );

    initial forever #5 clk = ~clk;

    // baud_x16_en high for one clock in every four, changed 2 time units after posedge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #2;
            div = div + 1;
            baud_x16_en = (div % 4 == 0);
        end
    end

    // FIFO pop on the DUT strobe.
    always @(posedge clk) begin
        if (rd_en[0]) erd[0] <= erd[0] + 1;
        if (rd_en[1]) erd[1] <= erd[1] + 1;
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural frame model ----------------
    int         stop_b [2] = '{1, 2};
    int         pod    [2] = '{0, 1};
    int         mrd    [2] = '{0, 0};
    int         kpos   [2] = '{0, 0};
    bit         active [2] = '{1'b0, 1'b0};
    bit         exp_pop[2] = '{1'b0, 1'b0};
    logic [7:0] cur    [2];
    int         pcnt = 0;
    bit         edge_was_baud = 1'b0;

    function automatic int nbits(input int i);
        return 9 + PBITS + stop_b[i];
    endfunction

    // Line value of bit b of the frame carrying ch.
    function automatic logic fbit(input logic [7:0] ch, input int b, input int i);
        if (b == 0) return 1'b0;
        if (b <= 8) return ch[b-1];
        if (PBITS == 1 && b == 9) return (^ch) ^ pod[i][0];
        return 1'b1;
    endfunction

    function automatic logic exp_txd(input int i);
        return active[i] ? fbit(cur[i], kpos[i] / 16, i) : 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_was_baud = 1'b0;
            for (int i = 0; i < 2; i++) begin
                active[i]  = 1'b0;
                exp_pop[i] = 1'b0;
            end
        end else begin
            edge_was_baud = baud_x16_en;
            if (baud_x16_en) pcnt++;
            for (int i = 0; i < 2; i++) begin
                exp_pop[i] = 1'b0;
                if (baud_x16_en) begin
                    if (active[i]) begin
                        kpos[i]++;
                        if (kpos[i] == 16 * nbits(i)) active[i] = 1'b0;
                    end
                    if (!active[i] && mrd[i] < push_cnt) begin
                        cur[i]     = push_mem[mrd[i] % 64];
                        mrd[i]++;
                        kpos[i]    = 0;
                        active[i]  = 1'b1;
                        exp_pop[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-scenario statistics ----------------
    int   rd_cnt [2];
    int   rd_pos [2][8];
    int   cap_len[2];
    int   falls  [2];
    logic cap    [2][1024];
    logic prev_busy [2] = '{1'b0, 1'b0};
    bit   run = 1'b0;

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            rd_cnt[i]  = 0;
            cap_len[i] = 0;
            falls[i]   = 0;
        end
    endtask

    function automatic int decode(input int i);
        int v;
        v = 0;
        for (int b = 0; b < 8; b++) if (cap[i][16 * (b + 1) + 8] === 1'b1) v |= (1 << b);
        return v;
    endfunction

    // Compare process: DUT against model every clock, sampled on the falling edge.
    always @(negedge clk) begin
        if (run && !rst) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("txd[%0d]", i), int'(txd[i]), int'(exp_txd(i)));
                check($sformatf("busy[%0d]", i), int'(busy[i]), int'(active[i]));
                check($sformatf("rd_en[%0d]", i), int'(rd_en[i]), int'(exp_pop[i]));
                if (rd_en[i]) begin
                    rd_pos[i][rd_cnt[i] % 8] = pcnt;
                    rd_cnt[i]++;
                end
                if (edge_was_baud && busy[i] && cap_len[i] < 1024) begin
                    cap[i][cap_len[i]] = txd[i];
                    cap_len[i]++;
                end
                if (prev_busy[i] && !busy[i]) falls[i]++;
                prev_busy[i] = busy[i];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] ch);
        push_mem[push_cnt % 64] = ch;
        push_cnt++;
    endtask

    task automatic wait_pulses(input int n);
        int target;
        target = pcnt + n;
        while (pcnt < target) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int start;
        start = pcnt;
        forever begin
            @(negedge clk);
            if (busy == 2'b00 && rd_en == 2'b00 &&
                erd[0] == push_cnt && erd[1] == push_cnt) break;
            if (pcnt - start > budget) begin
                check({name, "_idle_timeout"}, 0, 1);
                break;
            end
        end
    endtask

    int a5_seq [9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};

    // ---------------- main sequence ----------------
    initial begin
        int ones;
        int budget;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd0", int'(txd[0]), 1);
        check("reset_txd1", int'(txd[1]), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_rd_en", int'(rd_en), 0);
        #1 rst = 1'b0;
        run = 1'b1;

        // 1) Empty FIFO for 200 pulses: line idle, no pops.
        clear_stats();
        wait_pulses(200);
        check("s1_rd_cnt0", rd_cnt[0], 0);
        check("s1_rd_cnt1", rd_cnt[1], 0);
        check("s1_txd", int'(txd), 3);
        check("s1_busy", int'(busy), 0);

        // 2) Single 0xA5.
        clear_stats();
        push(8'hA5);
        wait_idle("s2", 600);
        check("s2_rd_cnt0", rd_cnt[0], 1);
        check("s2_rd_cnt1", rd_cnt[1], 1);
        check("s2_len0", cap_len[0], FRAME0);
        check("s2_len1", cap_len[1], FRAME1);
        for (int b = 0; b < 9; b++) begin
            check($sformatf("s2_bit%0d_dut0", b), int'(cap[0][16 * b + 8]), a5_seq[b]);
            check($sformatf("s2_bit%0d_dut1", b), int'(cap[1][16 * b + 8]), a5_seq[b]);
        end
`ifdef UART_TX_PARITY_EN
        check("s2_parity_dut0", int'(cap[0][152]), 0);
        check("s2_parity_dut1", int'(cap[1][152]), 1);
`else
        check("s2_stop_dut0", int'(cap[0][152]), 1);
`endif
        check("s2_busy_end", int'(busy), 0);

        // 3) 0x00 then 0xFF back to back.
        clear_stats();
        push(8'h00);
        push(8'hFF);
        wait_idle("s3", 1200);
        check("s3_rd_cnt0", rd_cnt[0], 2);
        check("s3_rd_cnt1", rd_cnt[1], 2);
        check("s3_rd_gap0", rd_pos[0][1] - rd_pos[0][0], FRAME0);
        check("s3_rd_gap1", rd_pos[1][1] - rd_pos[1][0], FRAME1);
        check("s3_busy_len0", cap_len[0], 2 * FRAME0);
        check("s3_busy_len1", cap_len[1], 2 * FRAME1);
        check("s3_busy_falls0", falls[0], 1);
        check("s3_busy_falls1", falls[1], 1);
        check("s3_first_data0", int'(cap[0][24]), 0);
        check("s3_second_start0", int'(cap[0][FRAME0 + 8]), 0);
        check("s3_second_data0", int'(cap[0][FRAME0 + 24]), 1);
        check("s3_last_stop0", int'(cap[0][FRAME0 - 1]), 1);

`ifdef UART_TX_PARITY_EN
        // 4) Parity of 0x07 (three ones).
        clear_stats();
        push(8'h07);
        wait_idle("s4", 600);
        check("s4_len0", cap_len[0], 176);
        check("s4_parity_even", int'(cap[0][152]), 1);
        check("s4_parity_odd", int'(cap[1][152]), 0);
`endif

        // 5) 0x3C twice; dut1 holds two stop bits (32 pulses).
        clear_stats();
        push(8'h3C);
        push(8'h3C);
        wait_idle("s5", 1200);
        ones = 0;
        for (int p = 0; p < 32; p++) if (cap[1][144 + 16 * PBITS + p] === 1'b1) ones++;
        check("s5_stop_high_dut1", ones, 32);
        check("s5_bit7_dut1", int'(cap[1][136]), 0);
        check("s5_next_start_dut1", int'(cap[1][FRAME1]), 0);
        check("s5_rd_gap1", rd_pos[1][1] - rd_pos[1][0], FRAME1);
        check("s5_rd_gap0", rd_pos[0][1] - rd_pos[0][0], FRAME0);
        check("s5_decode0", decode(0), 8'h3C);

        // 6) Reset 50 pulses into a 0x55 frame, then 0x12 queued during reset.
        clear_stats();
        push(8'h55);
        budget = 0;
        while (rd_cnt[0] == 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("s6_launch_seen", int'(rd_cnt[0] != 0), 1);
        wait_pulses(50);
        check("s6_busy_before_rst", int'(busy), 3);
        #1 rst = 1'b1;
        #1;
        check("s6_rst_txd", int'(txd), 3);
        check("s6_rst_busy", int'(busy), 0);
        check("s6_rst_rd_en", int'(rd_en), 0);
        push(8'h12);
        clear_stats();
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        wait_idle("s6", 600);
        check("s6_rd_cnt0", rd_cnt[0], 1);
        check("s6_rd_cnt1", rd_cnt[1], 1);
        check("s6_len0", cap_len[0], FRAME0);
        check("s6_start0", int'(cap[0][8]), 0);
        check("s6_decode0", decode(0), 8'h12);
        check("s6_decode1", decode(1), 8'h12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
